addsub_seq_accumulator: RTL
===========================

Name: addsub_seq_accumulator

Overview:
Sequential controller that drives a combinational WIDTH-bit add/sub stage.
- Loads an initial value, then applies acc <= acc ± operand a programmed number of times (rep_cnt).
- Reports the result, a sticky carry/borrow flag and a one-cycle done pulse.
- Serves as the operand and Sel source for the add/sub stage and consumes that stage's Sum and Cout.
- Supports repeated-add multiply and repeated-subtract decrement sequences.

Parameters:
WIDTH, 4, datapath width of accumulator, operand and add/sub stage
CNT_W, 3, width of repetition counter (max 2^CNT_W-1 steps)

Ports:
clk  input  1  system clock; all state changes on rising edge
RESET  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
op_sel  input  1  0 = add, 1 = subtract (two's complement, A + ~B + 1)
init_val  input  WIDTH  initial accumulator value, latched on accepted start
operand  input  WIDTH  B operand, latched on accepted start
rep_cnt  input  CNT_W  number of add/sub steps, latched on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse, high while state is DONE
acc_out  output  WIDTH  accumulator register, driven continuously
carry_flag  output  1  sticky: add = OR of all Cout; sub = OR of all borrows (~Cout)

Behaviour:
- Reset (RESET low, async): state=IDLE, acc=0, operand reg=0, op reg=0, cnt=0, carry_flag=0, busy=0, done=0. Applies immediately and aborts any sequence mid-run. Operation resumes on the first rising edge after RESET returns high.
- States: IDLE, RUN, DONE. Use an explicit encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- IDLE with start=1 at a clock edge:
  - acc<=init_val, B<=operand, op<=op_sel, cnt<=rep_cnt, carry_flag<=0.
  - Next state: RUN if rep_cnt!=0, else DONE.
- IDLE with start=0: all registers hold.
- RUN, each edge:
  - acc <= Sum of the add/sub stage (acc ± B, mod 2^WIDTH).
  - carry_flag <= carry_flag | (op ? ~Cout : Cout).
  - cnt <= cnt-1.
  - If cnt==1 before the edge, next state is DONE; otherwise stay in RUN.
- DONE: done=1 for exactly one cycle with acc_out/carry_flag stable, then IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing, and latched inputs are not modified.
- Latency: start sampled in cycle 0 → done high in cycle rep_cnt+1. This holds for rep_cnt=0 (done in cycle 1, acc=init_val, carry_flag=0).
- Changes to operand/op_sel/rep_cnt/init_val after acceptance have no effect.
- acc_out and carry_flag hold their final values in IDLE until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH; wrap-around is silent and reported only via carry_flag.
- Add/sub stage Sel is driven from the latched op register, not directly from op_sel.
- No combinational path from inputs to outputs. All outputs are registered or decoded from the state register.

Decomposition:
- Shared package/header: state encodings (S_IDLE, S_RUN, S_DONE) and default WIDTH=4, CNT_W=3.
- One sub-module: addsub_unit, the combinational WIDTH-bit adder/subtractor.
  - Inputs: A, B, Sel. Outputs: Cout, Sum.
  - Implements Sum = A + (B ^ {WIDTH{Sel}}) + Sel.
  - Instantiated once with A=acc, B=operand reg, Sel=op reg.
- FSM, counter and flag logic live in the top module.

Test Plan:
1. Add: init=0000, operand=0011, op=0, rep_cnt=4 → busy cycles 1-4, done in cycle 5, acc_out=1100, carry_flag=0.
2. Sub with borrow: init=0011, operand=0100, op=1, rep_cnt=1 → done in cycle 2, acc_out=1111, carry_flag=1. Repeat with init=0111, operand=0011 → acc_out=0100, carry_flag=0.
3. Add overflow: init=1110, operand=0101, op=0, rep_cnt=1 → acc_out=0011, carry_flag=1. Then init=0100, operand=1000, rep_cnt=1 → acc_out=1100, carry_flag=0.
4. Zero count: rep_cnt=000, init=1010, start → busy never high, done in cycle 1, acc_out=1010, carry_flag=0.
5. Wrap and max count: init=0000, operand=0001, op=1, rep_cnt=111 → done in cycle 8, acc_out=1001, carry_flag=1. Pulse start again in cycles 3 and 8 (done cycle) → both ignored, no second done.
6. Reset mid-run: start with rep_cnt=6, drop RESET in cycle 3 between edges → busy/done/acc_out/carry_flag go to 0 immediately. After release, a new start with rep_cnt=2, init=0001, operand=0001, add → acc_out=0011 in cycle 3.

Source files
------------

// File: rtl/addsub_seq_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// addsub_seq_accumulator_pkg
//
// Shared definitions for the sequential add/sub accumulator slice:
//   - state_t     : controller state encoding (IDLE / RUN / DONE)
//   - DEF_WIDTH   : default datapath width
//   - DEF_CNT_W   : default repetition-counter width
//   - flag_event(): per-step contribution to the sticky carry/borrow flag
// -----------------------------------------------------------------------------
package addsub_seq_accumulator_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // An add reports wrap-around through Cout; a two's-complement subtract
   // reports a borrow when Cout is clear.
   function automatic logic flag_event(input logic op, input logic cout);
      return op ? ~cout : cout;
   endfunction

endpackage : addsub_seq_accumulator_pkg

// File: rtl/addsub_seq_accumulator_addsub_unit.sv
// -----------------------------------------------------------------------------
// addsub_unit
//
// Combinational WIDTH-bit adder/subtractor.
//   Sum = A + (B ^ {WIDTH{Sel}}) + Sel   (Sel=1 gives A - B in two's complement)
//
// Ports:
//   A    in  WIDTH  first operand
//   B    in  WIDTH  second operand
//   Sel  in  1      0 = add, 1 = subtract
//   Cout out 1      carry out of the MSB
//   Sum  out WIDTH  result modulo 2^WIDTH
// -----------------------------------------------------------------------------
module addsub_unit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sel,
   output logic             Cout,
   output logic [WIDTH-1:0] Sum
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   total;

   assign b_eff = B ^ {WIDTH{Sel}};

   // One extra bit of headroom captures the carry out of the MSB.
   assign total = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Sel};

   assign Cout = total[WIDTH];
   assign Sum  = total[WIDTH-1:0];

endmodule : addsub_unit

// File: rtl/addsub_seq_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_seq_accumulator
//
// Loads an initial value, then applies acc <= acc +/- operand rep_cnt times
// through a single addsub_unit. Reports the result, a sticky carry/borrow
// flag and a one-cycle done pulse.
//
// Ports:
//   clk        in  1      system clock, rising edge
//   RESET      in  1      asynchronous, active-low reset
//   start      in  1      request, sampled only in IDLE
//   op_sel     in  1      0 = add, 1 = subtract
//   init_val   in  WIDTH  initial accumulator value, latched on start
//   operand    in  WIDTH  B operand, latched on start
//   rep_cnt    in  CNT_W  number of add/sub steps, latched on start
//   busy       out 1      high while in RUN
//   done       out 1      one-cycle pulse while in DONE
//   acc_out    out WIDTH  accumulator register
//   carry_flag out 1      sticky carry (add) / borrow (sub)
// -----------------------------------------------------------------------------
module addsub_seq_accumulator
   import addsub_seq_accumulator_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             start,
   input  logic             op_sel,
   input  logic [WIDTH-1:0] init_val,
   input  logic [WIDTH-1:0] operand,
   input  logic [CNT_W-1:0] rep_cnt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] acc_out,
   output logic             carry_flag
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             op_q,    op_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             flag_q,  flag_d;

   logic [WIDTH-1:0] stage_sum;
   logic             stage_cout;

   // The stage always sees the latched operand and operation, so input
   // changes after acceptance cannot disturb a running sequence.
   addsub_unit #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .A    (acc_q),
      .B    (b_q),
      .Sel  (op_q),
      .Cout (stage_cout),
      .Sum  (stage_sum)
   );

   // NOTE: every always_comb target gets its hold value first, so no path
   // through the case statement can leave a signal unassigned (no latches).
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = init_val;
               b_d     = operand;
               op_d    = op_sel;
               cnt_d   = rep_cnt;
               flag_d  = 1'b0;
               state_d = (rep_cnt != '0) ? S_RUN : S_DONE;
            end
         end

         S_RUN: begin
            acc_d  = stage_sum;
            flag_d = flag_q | flag_event(op_q, stage_cout);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: the reset is asynchronous (negedge RESET in the sensitivity list)
   // so a sequence is aborted immediately, not at the next clock edge.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from the
         // pre-edge values, matching the hardware regardless of statement order.
         state_q <= state_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
      end
   end

   // Outputs are registers or decodes of the state register only.
   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign acc_out    = acc_q;
   assign carry_flag = flag_q;

endmodule : addsub_seq_accumulator
